// File: rtl/mb128_serial_if.sv
// PC Engine joypad-port serial front end for the 128 KB save store: wake detect, command parse,
// byte-wide memory requests and read-bit return. Define MB128_TIMEOUT_EN to enable the idle abort.
module mb128_serial_if #(
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 262144
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pce_sel,
  input  logic              pce_clr,
  output logic [3:0]        pce_d,
  output logic              pce_d_oe,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              underrun
);

  localparam int unsigned LEN_W  = 20;
  localparam int unsigned AFLD_W = 10;
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]  WAKE   = 8'hA8;
`ifdef MB128_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_IDENT, S_CMD, S_ADDR, S_LEN, S_DATA, S_TRAIL
  } state_t;

  logic [SYNC_STAGES-1:0] sel_sync, clr_sync;
  logic                   clr_prev, clr_edge, sel_bit;

  state_t              state, state_n;
  logic [7:0]          wake_sr, wake_n, wake_shift;
  logic [LEN_W-1:0]    field_sr, field_n, field_shift;
  logic [4:0]          fcnt, fcnt_n;
  logic                is_read, is_read_n;
  logic [ADDR_W-1:0]   addr, addr_n;
  logic [LEN_W-1:0]    len_rem, len_n;
  logic [2:0]          bit_idx, bit_idx_n;
  logic [7:0]          wbyte, wbyte_n, wbyte_fill;
  logic [7:0]          rbyte, rbyte_n;
  logic                rvalid, rvalid_n;
  logic [1:0]          rd_out, rd_out_n, rd_skip, rd_skip_n;
  logic                hold_valid, hold_valid_n, hold_we, hold_we_n;
  logic [ADDR_W-1:0]   hold_addr, hold_addr_n;
  logic [7:0]          hold_data, hold_data_n;
  logic                trail, trail_n;
  logic [TO_W-1:0]     to_cnt, to_cnt_n;
  logic                underrun_n, busy_n, oe_n;
  logic [3:0]          pce_d_n;
  logic                mem_req_n, mem_we_n;
  logic [ADDR_W-1:0]   mem_addr_n;
  logic [7:0]          mem_wdata_n;
  logic                new_req, new_we, rd_done, abort;
  logic [ADDR_W-1:0]   new_addr;
  logic [7:0]          new_data;

  // Pin synchronisers and CLR rising-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_sync <= '0;
      clr_sync <= '0;
      clr_prev <= 1'b0;
    end else begin
      sel_sync <= {sel_sync[SYNC_STAGES-2:0], pce_sel};
      clr_sync <= {clr_sync[SYNC_STAGES-2:0], pce_clr};
      clr_prev <= clr_sync[SYNC_STAGES-1];
    end
  end

  assign clr_edge = clr_sync[SYNC_STAGES-1] & ~clr_prev;
  assign sel_bit  = sel_sync[SYNC_STAGES-1];

  always_comb begin
    state_n      = state;
    wake_n       = wake_sr;
    field_n      = field_sr;
    fcnt_n       = fcnt;
    is_read_n    = is_read;
    addr_n       = addr;
    len_n        = len_rem;
    bit_idx_n    = bit_idx;
    wbyte_n      = wbyte;
    rbyte_n      = rbyte;
    rvalid_n     = rvalid;
    rd_skip_n    = rd_skip;
    hold_valid_n = hold_valid;
    hold_we_n    = hold_we;
    hold_addr_n  = hold_addr;
    hold_data_n  = hold_data;
    trail_n      = trail;
    to_cnt_n     = to_cnt;
    underrun_n   = underrun;
    mem_req_n    = mem_req;
    mem_we_n     = mem_we;
    mem_addr_n   = mem_addr;
    mem_wdata_n  = mem_wdata;
    new_req      = 1'b0;
    new_we       = 1'b0;
    new_addr     = addr;
    new_data     = 8'h00;
    pce_d_n      = 4'h0;
    wake_shift   = {sel_bit, wake_sr[7:1]};
    field_shift  = {sel_bit, field_sr[LEN_W-1:1]};
    wbyte_fill   = wbyte;
    wbyte_fill[bit_idx] = sel_bit;
    rd_done      = mem_req && mem_ack && !mem_we;
    abort        = TIMEOUT_EN && (state != S_IDLE) && !clr_edge &&
                   (to_cnt == TO_W'(TIMEOUT_CYC));

    // Returned read data; reads issued for an abandoned byte slot are discarded
    if (mem_req && mem_ack) mem_req_n = 1'b0;
    if (rd_done) begin
      if (rd_skip != 2'd0) begin
        rd_skip_n = rd_skip - 2'd1;
      end else begin
        rbyte_n  = mem_rdata;
        rvalid_n = 1'b1;
      end
    end

    if (state == S_IDLE)  to_cnt_n = '0;
    else if (TIMEOUT_EN)  to_cnt_n = to_cnt + TO_W'(1);

    if (clr_edge) begin
      to_cnt_n = '0;
      unique case (state)
        S_IDLE: begin
          wake_n = wake_shift;
          if (wake_shift == WAKE) begin
            state_n    = S_IDENT;
            wake_n     = '0;
            underrun_n = 1'b0;
          end
        end
        S_IDENT: state_n = S_CMD;
        S_CMD: begin
          is_read_n = sel_bit;
          field_n   = '0;
          fcnt_n    = '0;
          state_n   = S_ADDR;
        end
        S_ADDR: begin
          field_n = field_shift;
          fcnt_n  = fcnt + 5'd1;
          if (fcnt == 5'd9) begin
            addr_n  = ADDR_W'({field_shift[LEN_W-1 -: AFLD_W], 7'b0});
            field_n = '0;
            fcnt_n  = '0;
            state_n = S_LEN;
          end
        end
        S_LEN: begin
          field_n = field_shift;
          fcnt_n  = fcnt + 5'd1;
          if (fcnt == 5'd19) begin
            len_n     = field_shift;
            bit_idx_n = '0;
            wbyte_n   = '0;
            rvalid_n  = 1'b0;
            rd_skip_n = rd_out - 2'(rd_done);
            if (field_shift == '0) begin
              state_n = S_TRAIL;
              trail_n = 1'b0;
            end else begin
              state_n = S_DATA;
              new_req = is_read;
            end
          end
        end
        S_DATA: begin
          len_n     = len_rem - LEN_W'(1);
          bit_idx_n = bit_idx + 3'd1;
          if (is_read) begin
            if (!rvalid) underrun_n = 1'b1;
            if (bit_idx == 3'd7 && len_rem != LEN_W'(1)) begin
              rvalid_n  = 1'b0;
              rd_skip_n = rd_out - 2'(rd_done);
              addr_n    = addr + ADDR_W'(1);
              new_req   = 1'b1;
              new_addr  = addr + ADDR_W'(1);
            end
          end else begin
            wbyte_n = wbyte_fill;
            if (bit_idx == 3'd7 || len_rem == LEN_W'(1)) begin
              new_req  = 1'b1;
              new_we   = 1'b1;
              new_data = wbyte_fill;
              addr_n   = addr + ADDR_W'(1);
              wbyte_n  = '0;
            end
          end
          if (len_rem == LEN_W'(1)) begin
            state_n = S_TRAIL;
            trail_n = 1'b0;
          end
        end
        S_TRAIL: begin
          trail_n = 1'b1;
          if (trail) state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end

    // One request in flight; a second one waits in the holding register
    if (!mem_req) begin
      if (hold_valid && !abort) begin
        mem_req_n    = 1'b1;
        mem_we_n     = hold_we;
        mem_addr_n   = hold_addr;
        mem_wdata_n  = hold_data;
        hold_valid_n = new_req;
        hold_we_n    = new_we;
        hold_addr_n  = new_addr;
        hold_data_n  = new_data;
      end else if (new_req) begin
        mem_req_n   = 1'b1;
        mem_we_n    = new_we;
        mem_addr_n  = new_addr;
        mem_wdata_n = new_data;
      end
    end else if (new_req) begin
      hold_valid_n = 1'b1;
      hold_we_n    = new_we;
      hold_addr_n  = new_addr;
      hold_data_n  = new_data;
    end

    if (abort) begin
      state_n      = S_IDLE;
      wake_n       = '0;
      hold_valid_n = 1'b0;
      to_cnt_n     = '0;
    end

    rd_out_n = rd_out - 2'(rd_done) + 2'(new_req && !new_we);

    busy_n = (state_n != S_IDLE);
    oe_n   = busy_n;
    if (state_n == S_IDENT)
      pce_d_n = 4'h4;
    else if (state_n == S_DATA && is_read_n)
      pce_d_n = {3'b000, rvalid_n & rbyte_n[bit_idx_n]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wake_sr    <= '0;
      field_sr   <= '0;
      fcnt       <= '0;
      is_read    <= 1'b0;
      addr       <= '0;
      len_rem    <= '0;
      bit_idx    <= '0;
      wbyte      <= '0;
      rbyte      <= '0;
      rvalid     <= 1'b0;
      rd_out     <= '0;
      rd_skip    <= '0;
      hold_valid <= 1'b0;
      hold_we    <= 1'b0;
      hold_addr  <= '0;
      hold_data  <= '0;
      trail      <= 1'b0;
      to_cnt     <= '0;
      underrun   <= 1'b0;
      busy       <= 1'b0;
      pce_d_oe   <= 1'b0;
      pce_d      <= 4'h0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_n;
      wake_sr    <= wake_n;
      field_sr   <= field_n;
      fcnt       <= fcnt_n;
      is_read    <= is_read_n;
      addr       <= addr_n;
      len_rem    <= len_n;
      bit_idx    <= bit_idx_n;
      wbyte      <= wbyte_n;
      rbyte      <= rbyte_n;
      rvalid     <= rvalid_n;
      rd_out     <= rd_out_n;
      rd_skip    <= rd_skip_n;
      hold_valid <= hold_valid_n;
      hold_we    <= hold_we_n;
      hold_addr  <= hold_addr_n;
      hold_data  <= hold_data_n;
      trail      <= trail_n;
      to_cnt     <= to_cnt_n;
      underrun   <= underrun_n;
      busy       <= busy_n;
      pce_d_oe   <= oe_n;
      pce_d      <= pce_d_n;
      mem_req    <= mem_req_n;
      mem_we     <= mem_we_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
    end
  end

endmodule

// File: tb/tb_mb128_serial_if.sv
// Bench for mb128_serial_if: host-side serial driver, memory responder and a byte-level
// model of expected requests and read bits.
module tb_mb128_serial_if;

  localparam int unsigned ADDR_W = 17;
  localparam int unsigned TO_CYC = 400;
  localparam int unsigned MEM_N  = 1 << ADDR_W;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } req_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pce_sel, pce_clr;
  logic [3:0]        pce_d;
  logic              pce_d_oe;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata, mem_rdata;
  logic              mem_ack;
  logic              busy, underrun;

  logic [7:0] mem [0:MEM_N-1];
  logic [7:0] wbuf [0:15];
  req_t       req_log [$];
  int         resp_lat_fixed = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  mb128_serial_if #(.ADDR_W(ADDR_W), .SYNC_STAGES(2), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .pce_sel(pce_sel), .pce_clr(pce_clr),
    .pce_d(pce_d), .pce_d_oe(pce_d_oe),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Memory responder: logs each request, acks after a short random latency
  initial begin : responder
    int   lat;
    req_t r;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && mem_req === 1'b1) begin
        r.we   = mem_we;
        r.addr = mem_addr;
        r.data = mem_we ? mem_wdata : 8'h00;
        req_log.push_back(r);
        lat = (resp_lat_fixed > 0) ? resp_lat_fixed : int'($urandom_range(1, 4));
        repeat (lat - 1) @(negedge clk);
        mem_rdata = mem[mem_addr];
        mem_ack   = 1'b1;
        @(negedge clk);
        mem_ack   = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One serial bit: data on SEL, then a CLR pulse; nib is pce_d just before the rising edge
  task automatic clk_bit(input logic b, output logic [3:0] nib);
    pce_sel = b;
    repeat (4) @(negedge clk);
    nib = pce_d;
    pce_clr = 1'b1;
    repeat (8) @(negedge clk);
    pce_clr = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    logic [3:0] nib;
    for (int i = 0; i < n; i++) clk_bit(v[i], nib);
  endtask

  task automatic xfer(input bit rd, input logic [9:0] a10, input int len, input bit slow_first);
    logic [3:0]        nib;
    logic [ADDR_W-1:0] base;
    logic [7:0]        eb;
    int                nbytes, start, rem;
    req_t              e;
    base   = {a10, 7'b0};
    nbytes = (len + 7) / 8;
    start  = req_log.size();
    send_bits(32'hA8, 8);
    chk("wake_oe", 32'(pce_d_oe), 32'd1);
    chk("wake_d", 32'(pce_d), 32'h4);
    chk("wake_underrun", 32'(underrun), 32'd0);
    clk_bit(1'($urandom_range(0, 1)), nib);
    clk_bit(rd, nib);
    send_bits(32'(a10), 10);
    if (slow_first) resp_lat_fixed = 20;
    send_bits(32'(len), 20);
    for (int k = 0; k < len; k++) begin
      if (rd) begin
        eb = mem[base + ADDR_W'(k / 8)];
        clk_bit(1'($urandom_range(0, 1)), nib);
        chk("rd_nibble", 32'(nib), (slow_first && k == 0) ? 32'd0 : 32'(eb[k % 8]));
      end else begin
        eb = wbuf[k / 8];
        clk_bit(eb[k % 8], nib);
      end
      resp_lat_fixed = 0;
    end
    chk("trail_d", 32'(pce_d), 32'd0);
    chk("trail_oe", 32'(pce_d_oe), 32'd1);
    send_bits(32'd0, 2);
    repeat (4) @(negedge clk);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_oe", 32'(pce_d_oe), 32'd0);
    chk("underrun", 32'(underrun), 32'(slow_first));
    chk("req_count", 32'(req_log.size() - start), 32'(nbytes));
    for (int i = 0; i < nbytes; i++) begin
      e.we   = !rd;
      e.addr = base + ADDR_W'(i);
      rem    = len - 8 * i;
      if (rd)            e.data = 8'h00;
      else if (rem >= 8) e.data = wbuf[i];
      else               e.data = wbuf[i] & 8'((1 << rem) - 1);
      if (start + i < req_log.size()) chk("req", 32'(req_log[start + i]), 32'(e));
      if (!rd) mem[e.addr] = e.data;
    end
  endtask

  initial begin : main
    int start;
    rst_n   = 1'b0;
    pce_sel = 1'b0;
    pce_clr = 1'b0;
    for (int i = 0; i < int'(MEM_N); i++) mem[i] = 8'($urandom);

    // Reset held while pins toggle
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      pce_sel = 1'($urandom);
      pce_clr = 1'($urandom);
    end
    chk("rst_d", 32'(pce_d), 32'd0);
    chk("rst_oe", 32'(pce_d_oe), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we_addr_wd", 32'({mem_we, mem_addr, mem_wdata}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    pce_sel = 1'b0;
    pce_clr = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_oe", 32'(pce_d_oe), 32'd0);

    // Wrong wake byte
    send_bits(32'hA7, 8);
    chk("a7_oe", 32'(pce_d_oe), 32'd0);
    chk("a7_busy", 32'(busy), 32'd0);

    // Directed write and read
    wbuf[0] = 8'h5A;
    wbuf[1] = 8'hC3;
    xfer(1'b0, 10'h003, 16, 1'b0);
    mem[17'h1FF80] = 8'h81;
    mem[17'h1FF81] = 8'h7E;
    xfer(1'b1, 10'h3FF, 16, 1'b0);

    // Late first byte, then a partial-byte write whose wake clears underrun
    xfer(1'b1, 10'($urandom), 16, 1'b1);
    wbuf[0] = 8'($urandom);
    wbuf[1] = 8'hFF;
    xfer(1'b0, 10'h010, 11, 1'b0);
    xfer(1'b1, 10'h010, 11, 1'b0);
    xfer(1'b0, 10'h020, 0, 1'b0);

`ifdef MB128_TIMEOUT_EN
    send_bits(32'hA8, 8);
    send_bits(32'h0, 2);
    send_bits(32'h5, 3);
    repeat (TO_CYC + 20) @(negedge clk);
    chk("timeout_oe", 32'(pce_d_oe), 32'd0);
    chk("timeout_busy", 32'(busy), 32'd0);
`endif

    // Reset in the middle of a write's data phase
    start = req_log.size();
    send_bits(32'hA8, 8);
    send_bits(32'h0, 2);
    send_bits(32'h005, 10);
    send_bits(32'd16, 20);
    send_bits(32'h15, 5);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_oe", 32'(pce_d_oe), 32'd0);
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_no_req", 32'(req_log.size() - start), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);

    // Randomised transfers
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
      xfer(1'($urandom_range(0, 1)), 10'($urandom), int'($urandom_range(0, 40)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
